// File: rtl/uart_tx_engine.sv
// UART transmitter: 8-bit frames with optional even/odd parity and 1 or 2 stop bits.
// A ready/valid handshake allows back-to-back frames with no idle gap on the line.
module uart_tx_engine #(
  parameter int unsigned CLOCK_FREQ = 50_000_000,
  parameter int unsigned BAUD_RATE  = 115_200,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       data_in_valid,
  output logic       data_in_ready,
  output logic       serial_out
);

  localparam int unsigned CLOCKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
  localparam int unsigned CNT_W = (CLOCKS_PER_BIT > 2) ? $clog2(CLOCKS_PER_BIT) : 1;
  localparam int unsigned IDX_W = 4;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLOCKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_PRE   = CNT_W'(CLOCKS_PER_BIT - 2);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);
  localparam logic             PAR_EN    = (PARITY != 0);
  localparam logic             PAR_ODD   = (PARITY == 2);

  if (CLOCKS_PER_BIT < 2 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_param_err
    $error("uart_tx_engine: illegal parameters (CLOCKS_PER_BIT=%0d PARITY=%0d STOP_BITS=%0d)",
           CLOCKS_PER_BIT, PARITY, STOP_BITS);
  end

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARBIT = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             par_q, par_d;
  logic             tx_d;
  logic             rdy_d;
  logic             accept_c;
  logic             wrap_c;

  assign accept_c = data_in_valid && data_in_ready;
  assign wrap_c   = (cnt_q == CNT_LAST);

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      bit_q         <= '0;
      shift_q       <= '0;
      par_q         <= 1'b0;
      serial_out    <= 1'b1;
      data_in_ready <= 1'b1;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_q         <= bit_d;
      shift_q       <= shift_d;
      par_q         <= par_d;
      serial_out    <= tx_d;
      data_in_ready <= rdy_d;
    end
  end

  // Next state, bit timing and line value
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = serial_out;
    rdy_d   = data_in_ready;

    if (state_q != IDLE) begin
      cnt_d = wrap_c ? '0 : cnt_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        tx_d  = 1'b1;
        rdy_d = 1'b1;
      end
      START: begin
        if (wrap_c) begin
          state_d = DATA;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (wrap_c) begin
          shift_d = shift_q >> 1;
          if (bit_q == IDX_W'(7)) begin
            bit_d = '0;
            if (PAR_EN) begin
              state_d = PARBIT;
              tx_d    = par_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d = bit_q + IDX_W'(1);
            tx_d  = shift_q[1];
          end
        end
      end
      PARBIT: begin
        if (wrap_c) begin
          state_d = STOP;
          bit_d   = '0;
          tx_d    = 1'b1;
        end
      end
      STOP: begin
        // Raise ready one cycle early so an accept lands on the final stop cycle
        if (bit_q == STOP_LAST && cnt_q == CNT_PRE) begin
          rdy_d = 1'b1;
        end
        if (wrap_c) begin
          if (bit_q == STOP_LAST) begin
            state_d = IDLE;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        bit_d   = '0;
        tx_d    = 1'b1;
        rdy_d   = 1'b1;
      end
    endcase

    if (accept_c) begin
      state_d = START;
      cnt_d   = '0;
      bit_d   = '0;
      shift_d = data_in;
      par_d   = PAR_ODD ? ~(^data_in) : (^data_in);
      tx_d    = 1'b0;
      rdy_d   = 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Bench for uart_tx_engine: four configurations (no parity, even, odd, two stop bits)
// with a line decoder per instance checking frames against a scoreboard queue.
module tb_uart_tx_engine;

  typedef struct {
    int         inst;
    logic [7:0] data;
    logic       par;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [7:0]  din  [4];
  logic        vld  [4];
  logic        rdy  [4];
  logic        sout [4];
  logic [3:0]  mon_en;
  int unsigned cyc;
  int unsigned n_checks;
  int unsigned n_fail;
  exp_t        exp_q[$];
  int unsigned starts0[$];

  uart_tx_engine #(.CLOCK_FREQ(1000), .BAUD_RATE(100), .PARITY(0), .STOP_BITS(1)) dut_p0 (
    .clk(clk), .rst(rst), .data_in(din[0]), .data_in_valid(vld[0]),
    .data_in_ready(rdy[0]), .serial_out(sout[0]));
  uart_tx_engine #(.CLOCK_FREQ(1000), .BAUD_RATE(100), .PARITY(1), .STOP_BITS(1)) dut_even (
    .clk(clk), .rst(rst), .data_in(din[1]), .data_in_valid(vld[1]),
    .data_in_ready(rdy[1]), .serial_out(sout[1]));
  uart_tx_engine #(.CLOCK_FREQ(1000), .BAUD_RATE(100), .PARITY(2), .STOP_BITS(1)) dut_odd (
    .clk(clk), .rst(rst), .data_in(din[2]), .data_in_valid(vld[2]),
    .data_in_ready(rdy[2]), .serial_out(sout[2]));
  uart_tx_engine #(.CLOCK_FREQ(1000), .BAUD_RATE(100), .PARITY(0), .STOP_BITS(2)) dut_stop2 (
    .clk(clk), .rst(rst), .data_in(din[3]), .data_in_valid(vld[3]),
    .data_in_ready(rdy[3]), .serial_out(sout[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cyc at a falling edge equals the number of the cycle in progress
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int unsigned c);
    while (cyc < c) @(negedge clk);
  endtask

  // Offer a byte; t returns the accept edge (the cycle in which ready was high)
  task automatic send(input int i, input logic [7:0] b, input bit push, output int unsigned t);
    int unsigned n;
    exp_t e;
    n = 0;
    din[i] = b;
    vld[i] = 1'b1;
    if (push) begin
      e.inst = i;
      e.data = b;
      e.par  = (i == 2) ? ~(^b) : (^b);
      exp_q.push_back(e);
    end
    while (rdy[i] !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check_eq("accept_wait", 32'(n < 500), 32'd1);
    t = cyc;
    @(negedge clk);
    vld[i] = 1'b0;
  endtask

  // Line decoder: detect start, sample each bit mid-period, compare with scoreboard
  for (genvar g = 0; g < 4; g++) begin : g_mon
    localparam int unsigned MP = (g == 1) ? 1 : ((g == 2) ? 2 : 0);
    localparam int unsigned MS = (g == 3) ? 2 : 1;
    always begin : mon
      logic [7:0] b;
      logic       pb;
      exp_t       e;
      pb = 1'b0;
      @(negedge clk);
      if (mon_en[g] && sout[g] === 1'b0) begin
        if (g == 0) starts0.push_back(cyc);
        repeat (4) @(negedge clk);
        check_eq("start_bit", 32'(sout[g]), 32'd0);
        for (int k = 0; k < 8; k++) begin
          repeat (10) @(negedge clk);
          b[k] = sout[g];
        end
        if (MP != 0) begin
          repeat (10) @(negedge clk);
          pb = sout[g];
        end
        for (int s = 0; s < int'(MS); s++) begin
          repeat (10) @(negedge clk);
          check_eq("stop_bit", 32'(sout[g]), 32'd1);
        end
        if (exp_q.size() == 0) begin
          check_eq("sb_unexpected_frame", 32'(b), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check_eq("sb_inst", 32'(g), 32'(e.inst));
          check_eq("sb_data", 32'(b), 32'(e.data));
          if (MP != 0) check_eq("sb_parity", 32'(pb), 32'(e.par));
        end
      end
    end
  end

  initial begin
    int unsigned t, t2;
    bit          hi;
    n_checks = 0;
    n_fail   = 0;
    mon_en   = 4'h0;
    rst      = 1'b1;
    for (int i = 0; i < 4; i++) begin
      din[i] = 8'h00;
      vld[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check_eq("reset_serial_out", 32'(sout[i]), 32'd1);
      check_eq("reset_ready", 32'(rdy[i]), 32'd1);
    end
    rst = 1'b0;
    @(negedge clk);
    mon_en = 4'hF;

    // Single byte, no parity
    send(0, 8'h55, 1'b1, t);
    check_eq("busy_after_accept", 32'(rdy[0]), 32'd0);
    wait_cyc(t + 99);
    check_eq("ready_low_t99", 32'(rdy[0]), 32'd0);
    wait_cyc(t + 100);
    check_eq("ready_high_t100", 32'(rdy[0]), 32'd1);
    hi = 1'b1;
    for (int c = 0; c <= 10; c++) begin
      wait_cyc(t + 100 + c);
      hi &= (sout[0] === 1'b1);
    end
    check_eq("idle_line_high", 32'(hi), 32'd1);

    // Back-to-back frames
    starts0.delete();
    send(0, 8'hA5, 1'b1, t);
    send(0, 8'h3C, 1'b1, t2);
    check_eq("b2b_accept_gap", t2 - t, 32'd100);
    wait_cyc(t + 199);
    check_eq("b2b_ready_low_t199", 32'(rdy[0]), 32'd0);
    wait_cyc(t + 200);
    check_eq("b2b_ready_high_t200", 32'(rdy[0]), 32'd1);
    wait_cyc(t + 210);
    check_eq("b2b_start_count", 32'(starts0.size()), 32'd2);
    if (starts0.size() == 2) begin
      check_eq("b2b_first_start", starts0[0], t + 1);
      check_eq("b2b_second_start", starts0[1], t + 101);
    end

    // Data change while busy
    send(0, 8'h12, 1'b1, t);
    wait_cyc(t + 30);
    send(0, 8'hFF, 1'b1, t2);
    check_eq("busy_accept_time", t2 - t, 32'd100);
    wait_cyc(t2 + 110);

    // Even and odd parity
    send(1, 8'h07, 1'b1, t);
    wait_cyc(t + 109);
    check_eq("even_ready_low_t109", 32'(rdy[1]), 32'd0);
    wait_cyc(t + 110);
    check_eq("even_ready_high_t110", 32'(rdy[1]), 32'd1);
    send(2, 8'h07, 1'b1, t);
    wait_cyc(t + 110);
    check_eq("odd_ready_high_t110", 32'(rdy[2]), 32'd1);
    wait_cyc(t + 115);

    // Two stop bits
    send(3, 8'h00, 1'b1, t);
    wait_cyc(t + 90);
    check_eq("stop2_last_data_bit", 32'(sout[3]), 32'd0);
    hi = 1'b1;
    for (int c = 91; c <= 110; c++) begin
      wait_cyc(t + c);
      hi &= (sout[3] === 1'b1);
    end
    check_eq("stop2_line_high", 32'(hi), 32'd1);
    check_eq("stop2_ready_t110", 32'(rdy[3]), 32'd1);
    wait_cyc(t + 120);

    // Reset mid-frame, then a clean frame
    mon_en[0] = 1'b0;
    send(0, 8'hC3, 1'b0, t);
    wait_cyc(t + 37);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("rst_serial_out_t38", 32'(sout[0]), 32'd1);
    @(negedge clk);
    check_eq("rst_ready_t39", 32'(rdy[0]), 32'd1);
    wait_cyc(t + 45);
    check_eq("rst_no_resume", 32'(sout[0]), 32'd1);
    mon_en[0] = 1'b1;
    send(0, 8'h81, 1'b1, t);
    wait_cyc(t + 110);

    check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
